pkt_rr_arb: RTL and testbench

PKT_RR_ARB -- requirements
Module: pkt_rr_arb

---
 rtl/pkt_arb_pkg.sv | 14 +
 rtl/pkt_rr_arb_pick.sv | 42 ++++
 rtl/pkt_rr_arb.sv | 109 ++++++++++
 tb/tb_pkt_rr_arb.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pkt_arb_pkg.sv
// rtl/pkt_arb_pkg.sv - shared types for the packet round-robin arbiter
package pkt_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    // Index following ptr, wrapping at np.
    function automatic int rr_next(input int ptr, input int step, input int np);
        return (ptr + step) % np;
    endfunction

endpackage

// File: rtl/pkt_rr_arb_pick.sv
// rtl/pkt_rr_arb_pick.sv - round-robin picker: request vector + pointer -> one-hot grant and index
//
// Ports:
//   req  - request vector, one bit per port
//   ptr  - index of the last winner; search starts at ptr+1
//   gnt  - one-hot grant (all zero when no request)
//   idx  - binary index of the granted port
//   any  - at least one request present
module pkt_rr_arb_pick
    import pkt_arb_pkg::*;
#(
    parameter int NP = 4
) (
    input  logic [NP-1:0]         req,
    input  logic [$clog2(NP)-1:0] ptr,
    output logic [NP-1:0]         gnt,
    output logic [$clog2(NP)-1:0] idx,
    output logic                  any
);

    localparam int IW = $clog2(NP);

    logic found;

    // Walk ptr+1 .. ptr+NP; the last step wraps back to ptr itself so a
    // lone persistent requester keeps winning.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= NP; i++) begin
            if (!found && req[rr_next(int'(ptr), i, NP)]) begin
                found = 1'b1;
                gnt[rr_next(int'(ptr), i, NP)] = 1'b1;
                idx = IW'(rr_next(int'(ptr), i, NP));
            end
        end
    end

    assign any = found;

endmodule

// File: rtl/pkt_rr_arb.sv
// rtl/pkt_rr_arb.sv - packet-locked round-robin merge of NP input streams into one registered stream
//
// Ports:
//   clk_i, rst_i          - clock and synchronous active-high reset
//   arb_en_i              - allows new grants; an in-flight packet always completes
//   in_data_i             - per-port data, port k at [k*DW +: DW]
//   in_vld_i, in_last_i   - per-port valid and end-of-packet marker
//   in_rdy_o              - per-port ready, only the locked port can see ready
//   out_data_o, out_vld_o,
//   out_last_o, out_src_o - registered merged stream and the source port of each beat
//   out_rdy_i             - downstream ready
//   busy_o                - a packet is locked
module pkt_rr_arb
    import pkt_arb_pkg::*;
#(
    parameter int NP = 4,
    parameter int DW = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  arb_en_i,
    input  logic [NP*DW-1:0]      in_data_i,
    input  logic [NP-1:0]         in_vld_i,
    input  logic [NP-1:0]         in_last_i,
    output logic [NP-1:0]         in_rdy_o,
    output logic [DW-1:0]         out_data_o,
    output logic                  out_vld_o,
    output logic                  out_last_o,
    input  logic                  out_rdy_i,
    output logic [$clog2(NP)-1:0] out_src_o,
    output logic                  busy_o
);

    localparam int IW = $clog2(NP);

    arb_state_t    state;
    logic [IW-1:0] gnt_idx;
    logic [NP-1:0] gnt_oh;
    logic [IW-1:0] rr_ptr;

    logic [NP-1:0] pick_gnt;
    logic [IW-1:0] pick_idx;
    logic          pick_any;

    logic          slot_free;
    logic          accept;
    logic          accept_last;
    logic [DW-1:0] sel_data;

    pkt_rr_arb_pick #(
        .NP (NP)
    ) u_pick (
        .req (in_vld_i),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // The output register can take a beat when empty or being drained now.
    assign slot_free   = !out_vld_o || out_rdy_i;
    assign in_rdy_o    = (state == ST_LOCK && slot_free) ? gnt_oh : '0;
    assign accept      = |(in_vld_i & in_rdy_o);
    assign accept_last = |(in_vld_i & in_rdy_o & in_last_i);
    assign sel_data    = in_data_i[gnt_idx*DW +: DW];
    assign busy_o      = (state == ST_LOCK);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            gnt_idx    <= '0;
            gnt_oh     <= '0;
            rr_ptr     <= IW'(NP - 1);
            out_data_o <= '0;
            out_vld_o  <= 1'b0;
            out_last_o <= 1'b0;
            out_src_o  <= '0;
        end else begin
            if (accept) begin
                out_data_o <= sel_data;
                out_last_o <= accept_last;
                out_src_o  <= gnt_idx;
                out_vld_o  <= 1'b1;
            end else if (out_vld_o && out_rdy_i) begin
                out_vld_o  <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (arb_en_i && pick_any) begin
                        state   <= ST_LOCK;
                        gnt_idx <= pick_idx;
                        gnt_oh  <= pick_gnt;
                        rr_ptr  <= pick_idx;
                    end
                end
                ST_LOCK: begin
                    // Only the last beat releases the lock; valid gaps and
                    // arb_en_i dropping do not.
                    if (accept_last) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_rr_arb.sv
// tb/tb_pkt_rr_arb.sv - randomized self-checking bench for pkt_rr_arb against a packet-level reference
module tb_pkt_rr_arb;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             arb_en;
    logic [NP*DW-1:0] in_data;
    logic [NP-1:0]    in_vld;
    logic [NP-1:0]    in_last;
    logic [NP-1:0]    in_rdy;
    logic [DW-1:0]    out_data;
    logic             out_vld;
    logic             out_last;
    logic             out_rdy;
    logic [IW-1:0]    out_src;
    logic             busy;

    pkt_rr_arb #(
        .NP (NP),
        .DW (DW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .arb_en_i   (arb_en),
        .in_data_i  (in_data),
        .in_vld_i   (in_vld),
        .in_last_i  (in_last),
        .in_rdy_o   (in_rdy),
        .out_data_o (out_data),
        .out_vld_o  (out_vld),
        .out_last_o (out_last),
        .out_rdy_i  (out_rdy),
        .out_src_o  (out_src),
        .busy_o     (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", tag, $time, obs, exp);
        end
    endtask

    // Per-port packet sources: each entry is {last, data}.
    logic [DW:0] srcq [NP][$];

    // Reference: who owns the output, which port won last, and what the
    // single output slot holds.
    bit          m_lock;
    int          m_own;
    int          m_last_win;
    bit          m_vld;
    logic [DW-1:0] m_data;
    bit          m_lastb;
    int          m_src;
    int          grant_log[$];

    task automatic model_reset();
        m_lock     = 0;
        m_own      = 0;
        m_last_win = NP - 1;
        m_vld      = 0;
        m_data     = '0;
        m_lastb    = 0;
        m_src      = 0;
    endtask

    task automatic drive(input logic [NP-1:0] mask, input int vld_pct, input int rdy_pct,
                         input int en_pct, input int rst_pct, input int maxlen);
        for (int p = 0; p < NP; p++) begin
            if (mask[p] && srcq[p].size() == 0) begin
                int len;
                len = $urandom_range(maxlen, 1);
                for (int b = 0; b < len; b++)
                    srcq[p].push_back({(b == len - 1), DW'($urandom)});
            end
            if (srcq[p].size() > 0 && ($urandom % 100) < vld_pct) begin
                in_vld[p]            = 1'b1;
                in_data[p*DW +: DW]  = srcq[p][0][DW-1:0];
                in_last[p]           = srcq[p][0][DW];
            end else begin
                in_vld[p]            = 1'b0;
                in_data[p*DW +: DW]  = DW'($urandom);
                in_last[p]           = 1'($urandom);
            end
        end
        out_rdy = (($urandom % 100) < rdy_pct);
        arb_en  = (($urandom % 100) < en_pct);
        rst     = (rst_pct >= 100) || (($urandom % 100) < rst_pct);
    endtask

    // Called mid-cycle: compare DUT against the reference, then step both
    // the reference and the sources for the coming clock edge.
    task automatic check_and_step();
        logic [NP-1:0] exp_rdy;
        bit slot, acc, was_lock;
        exp_rdy  = '0;
        was_lock = m_lock;
        slot     = !m_vld || out_rdy;
        if (m_lock && slot) exp_rdy[m_own] = 1'b1;

        check("in_rdy", 64'(in_rdy), 64'(exp_rdy));
        check("busy", 64'(busy), 64'(m_lock));
        check("out_vld", 64'(out_vld), 64'(m_vld));
        if (m_vld) begin
            check("out_data", 64'(out_data), 64'(m_data));
            check("out_last", 64'(out_last), 64'(m_lastb));
            check("out_src", 64'(out_src), 64'(m_src));
        end

        for (int p = 0; p < NP; p++)
            if (in_vld[p] && in_rdy[p]) void'(srcq[p].pop_front());

        acc = was_lock && in_vld[m_own] && slot;
        if (rst) begin
            model_reset();
        end else begin
            if (acc) begin
                m_vld   = 1;
                m_data  = in_data[m_own*DW +: DW];
                m_lastb = in_last[m_own];
                m_src   = m_own;
                if (in_last[m_own]) m_lock = 0;
            end else if (m_vld && out_rdy) begin
                m_vld = 0;
            end
            if (!was_lock && arb_en && (in_vld != '0)) begin
                for (int k = 1; k <= NP; k++) begin
                    int p;
                    p = (m_last_win + k) % NP;
                    if (!m_lock && in_vld[p]) begin
                        m_own      = p;
                        m_last_win = p;
                        m_lock     = 1;
                        grant_log.push_back(p);
                    end
                end
            end
        end
    endtask

    task automatic run(input int n, input logic [NP-1:0] mask, input int vld_pct, input int rdy_pct,
                       input int en_pct, input int rst_pct, input int maxlen);
        for (int c = 0; c < n; c++) begin
            drive(mask, vld_pct, rdy_pct, en_pct, rst_pct, maxlen);
            @(negedge clk);
            check_and_step();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst     = 1'b1;
        arb_en  = 1'b0;
        out_rdy = 1'b0;
        in_vld  = '0;
        in_last = '0;
        in_data = '0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset with garbage on the inputs, then the full reset state.
        run(3, 4'b0000, 0, 50, 50, 100, 1);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_src", 64'(out_src), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);

        // Port 2 alone, 3-beat packets, sink always ready; port 2 re-granted.
        grant_log.delete();
        run(20, 4'b0100, 100, 100, 100, 0, 3);
        check("p2_regrant", 64'(grant_log.size() >= 3), 64'd1);
        check("p2_first_owner", 64'(grant_log[0]), 64'd2);

        // Reset then all ports with 1-beat packets: strict 0,1,2,3,0 rotation.
        run(1, 4'b0000, 0, 100, 0, 100, 1);
        for (int p = 0; p < NP; p++) srcq[p].delete();
        grant_log.delete();
        run(12, 4'b1111, 100, 100, 100, 0, 1);
        for (int i = 0; i < 5; i++) check("rr_order", 64'(grant_log[i]), 64'(i % NP));

        // Backpressure-heavy traffic with valid gaps.
        run(300, 4'b1111, 60, 20, 100, 0, 4);

        // Everything random including occasional mid-packet resets.
        run(1500, 4'b1111, 70, 60, 80, 2, 4);

        // Grants disabled: a locked packet still completes, then stays idle.
        run(100, 4'b1111, 80, 70, 0, 0, 4);
        check("en_off_idle", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
